// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that serializes requester writes into a small register bank.
// Grant 1 cycle after request, ack 1 cycle later, 3 cycles per write; losers hold req until served.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  bank_q [DEPTH];
  logic [WIDTH-1:0]  bank_d [DEPTH];

  logic              sel_vld;
  logic [PW-1:0]     sel_idx;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin : arb_p
    int c;
    c        = 0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      c = (int'(ptr_q) + i) % NREQ;
      if (!sel_vld && req[c]) begin
        sel_vld  = 1'b1;
        sel_idx  = PW'(c);
        sel_addr = wr_addr[c*AW +: AW];
        sel_data = wr_data[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_d   = '0;
    ack_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bank_d[i] = bank_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          idx_d   = sel_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          gnt_d   = NREQ'(1) << sel_idx;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Out-of-range addresses match no register, so the write is dropped.
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_q == AW'(i)) begin
            bank_d[i] = data_q;
          end
        end
        gnt_d   = gnt_q;
        ack_d   = NREQ'(1) << idx_q;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = bank_q[i];
      end
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed writes, grant/ack order scoreboarded by a monitor.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int AW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NREQ-1:0] exp_gnt_q [$];
  logic [NREQ-1:0] exp_ack_q [$];
  logic [NREQ-1:0] prev_gnt = '0;
  logic [NREQ-1:0] prev_ack = '0;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr[k*AW +: AW]       = a;
    wr_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic expect_write(input logic [NREQ-1:0] v);
    exp_gnt_q.push_back(v);
    exp_ack_q.push_back(v);
  endtask

  task automatic read_chk(input string name, input int a, input logic [WIDTH-1:0] exp);
    rd_addr = AW'(a);
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_new_gnt();
    logic was;
    was = |gnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|gnt && !was) return;
      was = |gnt;
    end
    check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: grants and acks are popped from the scoreboard as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
      prev_ack = '0;
    end else begin
      if (gnt != '0 && prev_gnt == '0) begin
        if (exp_gnt_q.size() == 0) check("grant_unexpected", 32'(gnt), 32'd0);
        else check("grant_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (ack != '0) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
        else check("ack_vec", 32'(ack), 32'(exp_ack_q.pop_front()));
        check("ack_with_gnt", 32'(gnt), 32'(ack));
        check("ack_single_cycle", 32'(prev_ack), 32'd0);
      end
      prev_gnt = gnt;
      prev_ack = ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_cyc;
    last_cyc = 0;
    rst = 1'b1;
    req = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int a = 0; a < 4; a++) read_chk("rst_bank", a, 8'h00);

    // Single write: requester 0, addr 2, data A5.
    rst = 1'b0;
    @(negedge clk);
    set_slot(0, 2'd2, 8'hA5);
    rd_addr = 2'd2;
    expect_write(4'b0001);
    req = 4'b0001;
    @(negedge clk);
    check("t1_gnt_e0", 32'(gnt), 32'h1);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_ack_e0", 32'(ack), 32'd0);
    check("t1_old_read", 32'(rd_data), 32'h00);
    req = '0;
    @(negedge clk);
    check("t1_ack_e1", 32'(ack), 32'h1);
    check("t1_new_read", 32'(rd_data), 32'hA5);
    @(negedge clk);
    check("t1_gnt_e2", 32'(gnt), 32'd0);
    check("t1_ack_e2", 32'(ack), 32'd0);
    check("t1_busy_e2", 32'(busy), 32'd0);
    read_chk("t1_rd0", 0, 8'h00);
    read_chk("t1_rd1", 1, 8'h00);
    read_chk("t1_rd3", 3, 8'h00);

    // Sustained 1111 from ptr 0: grants 0,1,2,3,0, three cycles apart.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_slot(0, 2'd0, 8'h11);
    set_slot(1, 2'd1, 8'h22);
    set_slot(2, 2'd2, 8'h33);
    set_slot(3, 2'd0, 8'h44);
    expect_write(4'b0001);
    expect_write(4'b0010);
    expect_write(4'b0100);
    expect_write(4'b1000);
    expect_write(4'b0001);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_new_gnt();
      if (g > 0) check("t2_spacing", 32'(cyc) - last_cyc, 32'd3);
      last_cyc = 32'(cyc);
    end
    req = '0;
    wait_idle();
    read_chk("t2_rd0", 0, 8'h11);
    read_chk("t2_rd1", 1, 8'h22);
    read_chk("t2_rd2", 2, 8'h33);

    // Serve requester 1 alone so ptr lands on 2.
    set_slot(1, 2'd0, 8'h99);
    expect_write(4'b0010);
    req = 4'b0010;
    wait_new_gnt();
    req = '0;
    wait_idle();

    // req 0011 with ptr 2: requester 0 first; requester 1 drops req and data after grant.
    set_slot(0, 2'd1, 8'h5A);
    set_slot(1, 2'd2, 8'h3C);
    expect_write(4'b0001);
    expect_write(4'b0010);
    req = 4'b0011;
    wait_new_gnt();
    check("t3_first_gnt", 32'(gnt), 32'h1);
    req = 4'b0010;
    wait_new_gnt();
    req = '0;
    set_slot(1, 2'd2, 8'h00);
    wait_idle();
    read_chk("t3_rd0", 0, 8'h99);
    read_chk("t3_rd1", 1, 8'h5A);
    read_chk("t3_rd2", 2, 8'h3C);

    // Out-of-range write: ack still pulses, bank unchanged.
    set_slot(2, 2'd3, 8'hFF);
    expect_write(4'b0100);
    req = 4'b0100;
    wait_new_gnt();
    req = '0;
    wait_idle();
    read_chk("t4_rd0", 0, 8'h99);
    read_chk("t4_rd1", 1, 8'h5A);
    read_chk("t4_rd2", 2, 8'h3C);
    read_chk("t4_rd3", 3, 8'h00);

    // Reset between E0 and E1: write discarded, no ack, ptr back to 0.
    set_slot(1, 2'd1, 8'h77);
    exp_gnt_q.push_back(4'b0010);
    req = 4'b0010;
    wait_new_gnt();
    #2;
    rst = 1'b1;
    req = '0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    read_chk("t5_rd1", 1, 8'h00);
    read_chk("t5_rd0", 0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_slot(0, 2'd0, 8'h42);
    set_slot(3, 2'd2, 8'h24);
    expect_write(4'b0001);
    req = 4'b1001;
    wait_new_gnt();
    check("t5_gnt_from0", 32'(gnt), 32'h1);
    req = '0;
    wait_idle();
    read_chk("t5_after_rd0", 0, 8'h42);
    read_chk("t5_after_rd1", 1, 8'h00);
    read_chk("t5_after_rd2", 2, 8'h00);

    repeat (3) @(negedge clk);
    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
    check("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
